// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and default busy-cycle counts.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 4;

  // Operations that occupy the unit for a multi-cycle busy window.
  function automatic logic is_busy_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit result generator for mult/multu/div/divu. Ops that do
// not produce a new result (and divide by zero) pass the current HI/LO through.
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               a_neg;
  logic               b_neg;
  logic        [31:0] a_mag;
  logic        [31:0] b_mag;
  logic        [31:0] q_mag;
  logic        [31:0] r_mag;
  logic        [31:0] q_s;
  logic        [31:0] r_s;
  logic        [31:0] q_u;
  logic        [31:0] r_u;
  logic               div_zero;

  always_comb begin
    prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    prod_u = {32'd0, a_i} * {32'd0, b_i};
  end

  // Signed divide on magnitudes. 0x80000000 / -1 lands on q_mag = 0x80000000
  // with a positive sign, which is exactly the required wrapped quotient.
  always_comb begin
    div_zero = (b_i == 32'd0);
    a_neg    = a_i[31];
    b_neg    = b_i[31];
    a_mag    = a_neg ? (~a_i + 32'd1) : a_i;
    b_mag    = b_neg ? (~b_i + 32'd1) : b_i;
    q_mag    = div_zero ? 32'd0 : (a_mag / b_mag);
    r_mag    = div_zero ? 32'd0 : (a_mag % b_mag);
    q_s      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    r_s      = a_neg ? (~r_mag + 32'd1) : r_mag;
    q_u      = div_zero ? 32'd0 : (a_i / b_i);
    r_u      = div_zero ? 32'd0 : (a_i % b_i);
  end

  always_comb begin
    res_hi_o = hi_i;
    res_lo_o = lo_i;
    case (op_i)
      MD_MULT: begin
        res_hi_o = prod_s[63:32];
        res_lo_o = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi_o = prod_u[63:32];
        res_lo_o = prod_u[31:0];
      end
      MD_DIV: begin
        if (!div_zero) begin
          res_hi_o = r_s;
          res_lo_o = q_s;
        end
      end
      MD_DIVU: begin
        if (!div_zero) begin
          res_hi_o = r_u;
          res_lo_o = q_u;
        end
      end
      default: begin
        res_hi_o = hi_i;
        res_lo_o = lo_i;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models a multi-cycle operation by
// holding busy for a fixed count, then commits the precomputed result.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDout
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      tmp_hi_q;
  logic [31:0]      tmp_lo_q;
  logic [31:0]      tmp_hi_d;
  logic [31:0]      tmp_lo_d;

  md_arith u_arith (
    .op_i     (md_op),
    .a_i      (A),
    .b_i      (B),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .res_hi_o (tmp_hi_d),
    .res_lo_o (tmp_lo_d)
  );

  // start depends only on md_op and the registered busy, never on itself.
  assign start = is_busy_op(md_op) && !busy_q;
  assign busy  = busy_q;
  assign HI    = hi_q;
  assign LO    = lo_q;

  always_comb begin
    MDout = 32'd0;
    case (md_op)
      MD_MFHI: MDout = hi_q;
      MD_MFLO: MDout = lo_q;
      default: MDout = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            state_q  <= RUN;
            busy_q   <= 1'b1;
            cnt_q    <= is_mult_op(md_op) ? MULT_CNT : DIV_CNT;
          end else if (md_op == MD_MTHI) begin
            hi_q <= A;
          end else if (md_op == MD_MTLO) begin
            lo_q <= A;
          end
        end
        RUN: begin
          // Any MD op presented here is ignored; the result commits on the last count.
          cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            hi_q    <= tmp_hi_q;
            lo_q    <= tmp_lo_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, arithmetic results, mthi/mfhi,
// divide-by-zero hold, busy-time op rejection and asynchronous reset abort.
module tb_mult_div_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDout;

  int tests_run;
  int tests_failed;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .start (start),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO),
    .MDout (MDout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Counts busy cycles starting from the current one; stops at a bound.
  task automatic wait_idle(input int first, output int cyc);
    cyc = first;
    while (busy && cyc < 40) begin
      @(posedge clk); #1;
      if (busy) cyc++;
    end
  endtask

  // Presents an op for one edge, returns to MD_NONE, counts busy cycles.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    md_op = op; A = a; B = b;
    @(posedge clk); #1;
    md_op = MD_NONE; A = 32'd0; B = 32'd0;
    if (busy) wait_idle(1, cyc);
    else cyc = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1; md_op = MD_MFHI; A = 32'd0; B = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++;
    if (HI !== 32'd0 || LO !== 32'd0) begin
      tests_failed++; $display("FAIL reset_hilo: got HI=%h LO=%h want 0/0", HI, LO);
    end
    tests_run++;
    if (MDout !== 32'd0) begin tests_failed++; $display("FAIL reset_mdout: got %h want 0", MDout); end
    reset = 1'b0; md_op = MD_NONE;
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    int cyc;
    md_op = MD_MULT; A = 32'hFFFFFFFE; B = 32'd3;
    #1;
    tests_run++;
    if (start !== 1'b1) begin tests_failed++; $display("FAIL mult_start: got %b want 1", start); end
    run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, cyc);
    tests_run++;
    if (cyc != 5) begin tests_failed++; $display("FAIL mult_busy_cycles: got %0d want 5", cyc); end
    tests_run++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
      tests_failed++; $display("FAIL mult_result: got HI=%h LO=%h want ffffffff/fffffffa", HI, LO);
    end
    md_op = MD_MFLO; #1;
    tests_run++;
    if (MDout !== 32'hFFFFFFFA) begin tests_failed++; $display("FAIL mflo: got %h want fffffffa", MDout); end
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    tests_run++;
    if (cyc != 5 || HI !== 32'hFFFFFFFE || LO !== 32'h00000001) begin
      tests_failed++;
      $display("FAIL multu: got cyc=%0d HI=%h LO=%h want 5 fffffffe/00000001", cyc, HI, LO);
    end
  endtask

  task automatic test_div;
    int cyc;
    run_op(MD_DIVU, 32'd7, 32'd2, cyc);
    tests_run++;
    if (cyc != 10) begin tests_failed++; $display("FAIL divu_busy_cycles: got %0d want 10", cyc); end
    tests_run++;
    if (HI !== 32'd1 || LO !== 32'd3) begin
      tests_failed++; $display("FAIL divu_result: got HI=%h LO=%h want 1/3", HI, LO);
    end
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, cyc);
    tests_run++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      tests_failed++; $display("FAIL div_neg_dividend: got HI=%h LO=%h want ffffffff/fffffffd", HI, LO);
    end
    run_op(MD_DIV, 32'd7, 32'hFFFFFFFE, cyc);
    tests_run++;
    if (HI !== 32'd1 || LO !== 32'hFFFFFFFD) begin
      tests_failed++; $display("FAIL div_neg_divisor: got HI=%h LO=%h want 00000001/fffffffd", HI, LO);
    end
  endtask

  task automatic test_mthi_divzero;
    int cyc;
    md_op = MD_MTHI; A = 32'h12345678; #1;
    tests_run++;
    if (start !== 1'b0) begin tests_failed++; $display("FAIL mthi_start: got %b want 0", start); end
    @(posedge clk); #1;
    md_op = MD_MFHI; A = 32'd0; #1;
    tests_run++;
    if (MDout !== 32'h12345678 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL mfhi_after_mthi: got MDout=%h busy=%b want 12345678/0", MDout, busy);
    end
    md_op = MD_MTLO; A = 32'hCAFEF00D;
    @(posedge clk); #1;
    run_op(MD_DIV, 32'd5, 32'd0, cyc);
    tests_run++;
    if (cyc != 10) begin tests_failed++; $display("FAIL divzero_busy_cycles: got %0d want 10", cyc); end
    tests_run++;
    if (HI !== 32'h12345678 || LO !== 32'hCAFEF00D) begin
      tests_failed++; $display("FAIL divzero_hold: got HI=%h LO=%h want 12345678/cafef00d", HI, LO);
    end
    run_op(MD_DIVU, 32'd9, 32'd0, cyc);
    tests_run++;
    if (HI !== 32'h12345678 || LO !== 32'hCAFEF00D) begin
      tests_failed++; $display("FAIL divuzero_hold: got HI=%h LO=%h want 12345678/cafef00d", HI, LO);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    int bad_start;
    int bad_lo;
    md_op = MD_MULT; A = 32'd3; B = 32'd4;
    @(posedge clk); #1;
    md_op = MD_MULTU; A = 32'd5; B = 32'd6;
    cyc = 0; bad_start = 0; bad_lo = 0;
    while (busy && cyc < 40) begin
      cyc++;
      if (start !== 1'b0) bad_start++;
      if (LO !== 32'hCAFEF00D) bad_lo++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (bad_start != 0) begin tests_failed++; $display("FAIL b2b_start_while_busy: got %0d cycles with start=1 want 0", bad_start); end
    tests_run++;
    if (bad_lo != 0) begin tests_failed++; $display("FAIL b2b_lo_while_busy: got %0d early changes want 0", bad_lo); end
    tests_run++;
    if (cyc != 5) begin tests_failed++; $display("FAIL b2b_first_cycles: got %0d want 5", cyc); end
    tests_run++;
    if (start !== 1'b1 || HI !== 32'd0 || LO !== 32'd12) begin
      tests_failed++; $display("FAIL b2b_first_commit: got start=%b HI=%h LO=%h want 1 0/c", start, HI, LO);
    end
    @(posedge clk); #1;
    md_op = MD_NONE; A = 32'd0; B = 32'd0;
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_accept: got busy=%b want 1", busy); end
    wait_idle(1, cyc);
    tests_run++;
    if (cyc != 5 || HI !== 32'd0 || LO !== 32'd30) begin
      tests_failed++; $display("FAIL b2b_second_result: got cyc=%0d HI=%h LO=%h want 5 0/1e", cyc, HI, LO);
    end
  endtask

  task automatic test_reset_midrun;
    md_op = MD_MTHI; A = 32'hDEAD0000;
    @(posedge clk); #1;
    md_op = MD_DIV; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    md_op = MD_NONE; A = 32'd0; B = 32'd0;
    repeat (2) begin @(posedge clk); #1; end
    tests_run++;
    if (busy !== 1'b1 || HI !== 32'hDEAD0000) begin
      tests_failed++; $display("FAIL pre_reset_state: got busy=%b HI=%h want 1/dead0000", busy, HI);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      tests_failed++; $display("FAIL async_reset: got busy=%b HI=%h LO=%h want 0 0/0", busy, HI, LO);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      tests_failed++; $display("FAIL reset_no_commit: got busy=%b HI=%h LO=%h want 0 0/0", busy, HI, LO);
    end
  endtask

  task automatic test_div_overflow;
    int cyc;
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    tests_run++;
    if (cyc != 10 || HI !== 32'd0 || LO !== 32'h80000000) begin
      tests_failed++; $display("FAIL div_overflow: got cyc=%0d HI=%h LO=%h want 10 0/80000000", cyc, HI, LO);
    end
    md_op = 4'hF; A = 32'h55555555; B = 32'd1; #1;
    tests_run++;
    if (start !== 1'b0 || MDout !== 32'd0) begin
      tests_failed++; $display("FAIL unknown_op: got start=%b MDout=%h want 0/0", start, MDout);
    end
    @(posedge clk); #1;
    md_op = MD_MFLO; #1;
    tests_run++;
    if (busy !== 1'b0 || MDout !== 32'h80000000) begin
      tests_failed++; $display("FAIL unknown_op_no_effect: got busy=%b MDout=%h want 0/80000000", busy, MDout);
    end
    md_op = MD_NONE;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset;
    test_mult;
    test_div;
    test_mthi_divzero;
    test_back_to_back;
    test_reset_midrun;
    test_div_overflow;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
